tug_round_ctrl: RTL and testbench

//  Round controller for the tug-of-war game. Sequences the two player press latches (drives their

---
 rtl/tug_pkg.sv | 38 +++
 rtl/tug_round_ctrl_if.sv | 24 ++
 rtl/tug_timer.sv | 31 +++
 rtl/tug_round_ctrl.sv | 157 +++++++++++++++
 tb/tb_tug_round_ctrl.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/tug_pkg.sv
// Shared definitions for the tug-of-war round controller: state encoding,
// default geometry/timing and the press arbitration helper.
package tug_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ARMED = 3'd1,
        ST_PLAY  = 3'd2,
        ST_LOCK  = 3'd3,
        ST_WIN   = 3'd4
    } state_e;

    typedef enum logic [1:0] {
        MV_NONE  = 2'd0,
        MV_LEFT  = 2'd1,
        MV_RIGHT = 2'd2,
        MV_TIE   = 2'd3
    } move_e;

    localparam int WIN_DIST_DEF  = 3;
    localparam int POS_W_DEF     = 3;
    localparam int COUNT_CYC_DEF = 50000;
    localparam int HOLD_CYC_DEF  = 1000;
    localparam int CNT_W_DEF     = 16;
    localparam int POS_CENTRE    = WIN_DIST_DEF;

    function automatic move_e arbitrate(input logic l, input logic r);
        move_e m;
        case ({l, r})
            2'b10:   m = MV_LEFT;
            2'b01:   m = MV_RIGHT;
            2'b11:   m = MV_TIE;
            default: m = MV_NONE;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/tug_round_ctrl_if.sv
// Bundle between the round controller and the press latches / display logic.
// master = controller side, slave = latches, referee and display side.
interface tug_round_ctrl_if #(
    parameter int POS_W = 3
);
    logic             start;
    logic             pbl;
    logic             pbr;
    logic             clear;
    logic [POS_W-1:0] pos;
    logic             winner_l;
    logic             winner_r;
    logic             playing;

    modport master (
        input  start, pbl, pbr,
        output clear, pos, winner_l, winner_r, playing
    );

    modport slave (
        output start, pbl, pbr,
        input  clear, pos, winner_l, winner_r, playing
    );
endinterface

// File: rtl/tug_timer.sv
// Down-counter shared by the countdown and the post-score lockout.
// Load takes priority; the count parks at zero.
module tug_timer #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             en,
    output logic             zero
);

    logic [CNT_W-1:0] cnt_r;

    // Count register with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (load) begin
            cnt_r <= load_val;
        end else if (en && (cnt_r != {CNT_W{1'b0}})) begin
            cnt_r <= cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign zero = (cnt_r == {CNT_W{1'b0}});

endmodule

// File: rtl/tug_round_ctrl.sv
// Tug-of-war round controller: clears the press latches, arbitrates presses,
// moves the rope and declares a winner. Optional macro FALSE_START_EN penalises presses during the countdown.
module tug_round_ctrl
    import tug_pkg::*;
#(
    parameter int WIN_DIST  = WIN_DIST_DEF,
    parameter int POS_W     = POS_W_DEF,
    parameter int COUNT_CYC = COUNT_CYC_DEF,
    parameter int HOLD_CYC  = HOLD_CYC_DEF,
    parameter int CNT_W     = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    tug_round_ctrl_if.master bus
);

    localparam logic [POS_W-1:0] CENTRE     = POS_W'(WIN_DIST);
    localparam logic [POS_W-1:0] POS_MAX    = POS_W'(2 * WIN_DIST);
    localparam logic [POS_W-1:0] POS_ONE    = {{(POS_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] COUNT_LOAD = CNT_W'(COUNT_CYC - 1);
    localparam logic [CNT_W-1:0] HOLD_LOAD  = CNT_W'(HOLD_CYC - 1);

    state_e           state_r, state_s;
    logic [POS_W-1:0] pos_r, pos_s, new_pos_s;
    logic             wl_r, wl_s, wr_r, wr_s;
    logic             clear_r, clear_s;
    logic             playing_r;
    logic             tmr_load_s, tmr_en_s, tmr_zero_s;
    logic [CNT_W-1:0] tmr_val_s;
    logic             flip_s, scoring_s;
    move_e            move_s;

    tug_timer #(.CNT_W(CNT_W)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load_s),
        .load_val (tmr_val_s),
        .en       (tmr_en_s),
        .zero     (tmr_zero_s)
    );

    // Decide whether this cycle's press scores and where it moves the rope
    always_comb begin
        move_s = arbitrate(bus.pbl, bus.pbr);
`ifdef FALSE_START_EN
        // A false start pulls the rope toward the offender's opponent
        flip_s    = (state_r == ST_ARMED);
        scoring_s = (move_s != MV_NONE) &&
                    ((state_r == ST_PLAY) || (state_r == ST_ARMED));
`else
        flip_s    = 1'b0;
        scoring_s = (move_s != MV_NONE) && (state_r == ST_PLAY);
`endif
        case (move_s)
            MV_LEFT:  new_pos_s = flip_s ? (pos_r + POS_ONE) : (pos_r - POS_ONE);
            MV_RIGHT: new_pos_s = flip_s ? (pos_r - POS_ONE) : (pos_r + POS_ONE);
            default:  new_pos_s = pos_r;
        endcase
    end

    // Next-state, rope position, winner flags and timer control
    always_comb begin
        state_s    = state_r;
        pos_s      = pos_r;
        wl_s       = wl_r;
        wr_s       = wr_r;
        tmr_load_s = 1'b0;
        tmr_val_s  = COUNT_LOAD;
        tmr_en_s   = 1'b0;
        if (scoring_s) begin
            pos_s = new_pos_s;
            if (new_pos_s == {POS_W{1'b0}}) begin
                state_s = ST_WIN;
                wl_s    = 1'b1;
            end else if (new_pos_s == POS_MAX) begin
                state_s = ST_WIN;
                wr_s    = 1'b1;
            end else begin
                state_s    = ST_LOCK;
                tmr_load_s = 1'b1;
                tmr_val_s  = HOLD_LOAD;
            end
        end else begin
            case (state_r)
                ST_IDLE, ST_WIN: begin
                    if (bus.start) begin
                        state_s    = ST_ARMED;
                        pos_s      = CENTRE;
                        wl_s       = 1'b0;
                        wr_s       = 1'b0;
                        tmr_load_s = 1'b1;
                        tmr_val_s  = COUNT_LOAD;
                    end else begin
                        state_s = state_r;
                    end
                end
                ST_ARMED, ST_LOCK: begin
                    if (tmr_zero_s) begin
                        state_s = ST_PLAY;
                    end else begin
                        tmr_en_s = 1'b1;
                    end
                end
                ST_PLAY: state_s = ST_PLAY;
                default: begin
                    state_s = ST_IDLE;
                    pos_s   = CENTRE;
                    wl_s    = 1'b0;
                    wr_s    = 1'b0;
                end
            endcase
        end
    end

    // Latch clear is released only while presses can score
    always_comb begin
`ifdef FALSE_START_EN
        if ((state_s == ST_PLAY) || (state_s == ST_ARMED)) begin
            clear_s = 1'b0;
        end else begin
            clear_s = 1'b1;
        end
`else
        if (state_s == ST_PLAY) begin
            clear_s = 1'b0;
        end else begin
            clear_s = 1'b1;
        end
`endif
    end

    // State and output registers; outputs track the state being entered
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r   <= ST_IDLE;
            pos_r     <= CENTRE;
            wl_r      <= 1'b0;
            wr_r      <= 1'b0;
            clear_r   <= 1'b1;
            playing_r <= 1'b0;
        end else begin
            state_r   <= state_s;
            pos_r     <= pos_s;
            wl_r      <= wl_s;
            wr_r      <= wr_s;
            clear_r   <= clear_s;
            playing_r <= (state_s == ST_PLAY);
        end
    end

    assign bus.clear    = clear_r;
    assign bus.pos      = pos_r;
    assign bus.winner_l = wl_r;
    assign bus.winner_r = wr_r;
    assign bus.playing  = playing_r;

endmodule

// File: tb/tb_tug_round_ctrl.sv
// Self-checking bench for tug_round_ctrl (WIN_DIST=3, COUNT_CYC=4, HOLD_CYC=2):
// directed round with literal expectations, then random play against a phase/countdown model.
module tb_tug_round_ctrl;

    localparam int WD    = 3;
    localparam int COUNT = 4;
    localparam int HOLD  = 2;
`ifdef FALSE_START_EN
    localparam bit FS = 1'b1;
    localparam int N_TO_5 = 1;
`else
    localparam bit FS = 1'b0;
    localparam int N_TO_5 = 2;
`endif
    localparam int ARMED_CLEAR = FS ? 0 : 1;

    localparam int P_IDLE = 0, P_ARMED = 1, P_PLAY = 2, P_LOCK = 3, P_WIN = 4;

    logic clk;
    logic rst;
    int   checks = 0;
    int   failures = 0;
    bit   cmp_en = 1'b0;

    // model: phase, cycles left in phase, rope position, winners
    int ph = P_IDLE, rem = 0, mpos = WD;
    bit mwl = 1'b0, mwr = 1'b0;

    tug_round_ctrl_if #(.POS_W(3)) bus ();

    tug_round_ctrl #(
        .WIN_DIST(WD), .POS_W(3), .COUNT_CYC(COUNT), .HOLD_CYC(HOLD), .CNT_W(16)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input int exp);
        checks++;
        if (act !== 32'(exp)) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic adv();
        @(negedge clk);
    endtask

    task automatic press(input logic l, input logic r);
        bus.pbl = l;
        bus.pbr = r;
        adv();
        bus.pbl = 1'b0;
        bus.pbr = 1'b0;
    endtask

    task score(input int d);
        mpos = mpos + d;
        if (mpos == 0) begin
            ph = P_WIN; mwl = 1'b1;
        end else if (mpos == 2 * WD) begin
            ph = P_WIN; mwr = 1'b1;
        end else begin
            ph = P_LOCK; rem = HOLD;
        end
    endtask

    // reference model advanced on the same edge the DUT samples
    always @(posedge clk) begin
        if (!rst) begin
            ph = P_IDLE; rem = 0; mpos = WD; mwl = 1'b0; mwr = 1'b0;
        end else begin
            case (ph)
                P_IDLE, P_WIN: if (bus.start) begin
                    ph = P_ARMED; rem = COUNT; mpos = WD; mwl = 1'b0; mwr = 1'b0;
                end
                P_ARMED: begin
                    if (FS && (bus.pbl || bus.pbr)) begin
                        score((bus.pbl && !bus.pbr) ? 1 : ((bus.pbr && !bus.pbl) ? -1 : 0));
                    end else begin
                        rem = rem - 1;
                        if (rem == 0) ph = P_PLAY;
                    end
                end
                P_PLAY: if (bus.pbl || bus.pbr) begin
                    score((bus.pbl && !bus.pbr) ? -1 : ((bus.pbr && !bus.pbl) ? 1 : 0));
                end
                P_LOCK: begin
                    rem = rem - 1;
                    if (rem == 0) ph = P_PLAY;
                end
                default: ph = P_IDLE;
            endcase
        end
    end

    // every-cycle comparison of all outputs against the model
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("m_pos", bus.pos, mpos);
            chk("m_clear", bus.clear, (ph == P_PLAY || (FS && ph == P_ARMED)) ? 0 : 1);
            chk("m_playing", bus.playing, (ph == P_PLAY) ? 1 : 0);
            chk("m_winner_l", bus.winner_l, mwl);
            chk("m_winner_r", bus.winner_r, mwr);
        end
    end

    initial begin
        rst = 1'b0;
        bus.start = 1'b0;
        bus.pbl = 1'b0;
        bus.pbr = 1'b0;
        adv();
        adv();
        cmp_en = 1'b1;
        chk("rst_pos", bus.pos, 3);
        chk("rst_clear", bus.clear, 1);
        chk("rst_wl", bus.winner_l, 0);
        chk("rst_wr", bus.winner_r, 0);
        chk("rst_playing", bus.playing, 0);
        rst = 1'b1;
        repeat (3) adv();
        chk("idle_clear", bus.clear, 1);
        chk("idle_playing", bus.playing, 0);

        bus.start = 1'b1;
        adv();
        bus.start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("armed_playing", bus.playing, 0);
            chk("armed_clear", bus.clear, ARMED_CLEAR);
            adv();
        end
        chk("play_playing", bus.playing, 1);
        chk("play_clear", bus.clear, 0);

        press(1'b0, 1'b1);
        chk("score_pos", bus.pos, 4);
        chk("lock_clear1", bus.clear, 1);
        adv();
        chk("lock_clear2", bus.clear, 1);
        adv();
        chk("relock_playing", bus.playing, 1);
        chk("relock_clear", bus.clear, 0);

        press(1'b1, 1'b1);
        chk("tie_pos", bus.pos, 4);
        chk("tie_clear", bus.clear, 1);
        adv();
        adv();
        chk("tie_playing", bus.playing, 1);

        for (int k = 3; k >= 1; k--) begin
            press(1'b1, 1'b0);
            chk("left_pos", bus.pos, k);
            adv();
            adv();
        end
        press(1'b1, 1'b0);
        chk("win_pos", bus.pos, 0);
        chk("win_wl", bus.winner_l, 1);
        chk("win_wr", bus.winner_r, 0);
        chk("win_clear", bus.clear, 1);
        adv();
        chk("win_hold_wl", bus.winner_l, 1);

        bus.start = 1'b1;
        adv();
        bus.start = 1'b0;
        chk("restart_pos", bus.pos, 3);
        chk("restart_wl", bus.winner_l, 0);
        chk("restart_clear", bus.clear, ARMED_CLEAR);
`ifdef FALSE_START_EN
        press(1'b1, 1'b0);
        chk("fs_pos", bus.pos, 4);
        chk("fs_clear", bus.clear, 1);
        adv();
        adv();
        chk("fs_playing", bus.playing, 1);
`else
        repeat (4) adv();
        chk("restart_playing", bus.playing, 1);
`endif

        for (int k = 0; k < N_TO_5 - 1; k++) begin
            press(1'b0, 1'b1);
            adv();
            adv();
        end
        press(1'b0, 1'b1);
        chk("pre_rst_pos", bus.pos, 5);
        chk("pre_rst_clear", bus.clear, 1);
        rst = 1'b0;
        adv();
        rst = 1'b1;
        chk("midlock_rst_pos", bus.pos, 3);
        chk("midlock_rst_clear", bus.clear, 1);
        chk("midlock_rst_playing", bus.playing, 0);

        for (int n = 0; n < 4000; n++) begin
            rst       = ($urandom_range(0, 199) != 0);
            bus.start = ($urandom_range(0, 7) == 0);
            bus.pbl   = ($urandom_range(0, 3) == 0);
            bus.pbr   = ($urandom_range(0, 3) == 0);
            adv();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
